async_proc_paulschulz: RTL and testbench

- Tiny 8-bit accumulator processor packaged as a TinyTapeout user tile.
- Holds a 16-byte program/data memory, loaded serially through the dedicated inputs, then executed at one instruction per clock.
- Results appear on the dedicated outputs; status appears on the upper bidirectional pins.

---
 rtl/async_proc_paulschulz_if.sv | 28 ++
 rtl/async_proc_paulschulz.sv | 160 ++++++++++++++++
 tb/tb_async_proc_paulschulz.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/async_proc_paulschulz_if.sv
// Tile I/O bundle for the accumulator processor: load/run controls in, result and status out.
// master drives the stimulus side, slave is the processor tile.
interface async_proc_paulschulz_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena,
        output ui_in,
        output uio_in,
        input  uo_out,
        input  uio_out,
        input  uio_oe
    );

    modport slave (
        input  ena,
        input  ui_in,
        input  uio_in,
        output uo_out,
        output uio_out,
        output uio_oe
    );
endinterface

// File: rtl/async_proc_paulschulz.sv
// 8-bit accumulator processor tile: 16-byte memory loaded serially, then executed one
// instruction per clock. Result register on uo_out, status flags on uio_out[7:4].
module async_proc_paulschulz #(
    parameter int unsigned MemDepth = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    async_proc_paulschulz_if.slave       bus
);

    typedef enum logic [3:0] {
        OpNop  = 4'h0, OpLdi  = 4'h1, OpAddi = 4'h2, OpSubi = 4'h3,
        OpAddm = 4'h4, OpLdm  = 4'h5, OpStm  = 4'h6, OpOut  = 4'h7,
        OpIn   = 4'h8, OpJmp  = 4'h9, OpJz   = 4'hA, OpJc   = 4'hB,
        OpShl  = 4'hC, OpShr  = 4'hD, OpXorm = 4'hE, OpHalt = 4'hF
    } op_e;

    logic [7:0] mem_q [MemDepth];
    logic [7:0] mem_d [MemDepth];
    logic [3:0] pc_q, pc_d;
    logic [3:0] lp_q, lp_d;
    logic [7:0] a_q, a_d;
    logic       c_q, c_d;
    logic       z_q, z_d;
    logic [7:0] outr_q, outr_d;
    logic       halted_q, halted_d;

    logic       wr, run, clr;
    logic [7:0] instr;
    op_e        op;
    logic [3:0] k;
    logic [7:0] operand;
    logic [8:0] alu;
    logic       upd_z;
    logic       running;
    logic       unused_uio;

    assign wr         = bus.uio_in[0];
    assign run        = bus.uio_in[1];
    assign clr        = bus.uio_in[2];
    assign unused_uio = ^bus.uio_in[7:3];

    assign instr   = mem_q[pc_q];
    assign op      = op_e'(instr[7:4]);
    assign k       = instr[3:0];
    assign operand = mem_q[k];

    always_comb begin
        mem_d    = mem_q;
        pc_d     = pc_q;
        lp_d     = lp_q;
        a_d      = a_q;
        c_d      = c_q;
        z_d      = z_q;
        outr_d   = outr_q;
        halted_d = halted_q;
        alu      = 9'd0;
        upd_z    = 1'b0;

        if (bus.ena) begin
            if (!run) begin
                pc_d     = 4'd0;
                halted_d = 1'b0;
                if (clr) begin
                    lp_d = 4'd0;
                end else if (wr) begin
                    mem_d[lp_q] = bus.ui_in;
                    lp_d        = lp_q + 4'd1;
                end
            end else if (!halted_q) begin
                pc_d = pc_q + 4'd1;
                case (op)
                    OpNop: ;
                    OpLdi: begin
                        a_d   = {4'd0, k};
                        upd_z = 1'b1;
                    end
                    OpAddi: begin
                        alu        = {1'b0, a_q} + {5'd0, k};
                        {c_d, a_d} = alu;
                        upd_z      = 1'b1;
                    end
                    OpSubi: begin
                        // Bit 8 of the 9-bit difference is the borrow.
                        alu   = {1'b0, a_q} - {5'd0, k};
                        a_d   = alu[7:0];
                        c_d   = alu[8];
                        upd_z = 1'b1;
                    end
                    OpAddm: begin
                        alu        = {1'b0, a_q} + {1'b0, operand};
                        {c_d, a_d} = alu;
                        upd_z      = 1'b1;
                    end
                    OpLdm: begin
                        a_d   = operand;
                        upd_z = 1'b1;
                    end
                    OpStm:  mem_d[k] = a_q;
                    OpOut:  outr_d   = a_q;
                    OpIn: begin
                        a_d   = bus.ui_in;
                        upd_z = 1'b1;
                    end
                    OpJmp:  pc_d = k;
                    OpJz:   if (z_q) pc_d = k;
                    OpJc:   if (c_q) pc_d = k;
                    OpShl: begin
                        c_d   = a_q[7];
                        a_d   = {a_q[6:0], 1'b0};
                        upd_z = 1'b1;
                    end
                    OpShr: begin
                        c_d   = a_q[0];
                        a_d   = {1'b0, a_q[7:1]};
                        upd_z = 1'b1;
                    end
                    OpXorm: begin
                        a_d   = a_q ^ operand;
                        upd_z = 1'b1;
                    end
                    OpHalt: begin
                        halted_d = 1'b1;
                        pc_d     = pc_q;
                    end
                endcase
                if (upd_z) z_d = (a_d == 8'd0);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MemDepth; i++) mem_q[i] <= 8'h00;
            pc_q     <= 4'd0;
            lp_q     <= 4'd0;
            a_q      <= 8'd0;
            c_q      <= 1'b0;
            z_q      <= 1'b0;
            outr_q   <= 8'd0;
            halted_q <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            pc_q     <= pc_d;
            lp_q     <= lp_d;
            a_q      <= a_d;
            c_q      <= c_d;
            z_q      <= z_d;
            outr_q   <= outr_d;
            halted_q <= halted_d;
        end
    end

    // Gated by rst so the status pins read zero for the whole reset pulse.
    assign running     = run & ~halted_q & ~rst;
    assign bus.uo_out  = outr_q;
    assign bus.uio_out = {halted_q, running, c_q, z_q, 4'b0000};
    assign bus.uio_oe  = 8'hF0;

endmodule

// File: tb/tb_async_proc_paulschulz.sv
// Directed bench for the accumulator tile: loads small programs and checks results/status.
module tb_async_proc_paulschulz;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic wr  = 1'b0;
    logic run = 1'b0;
    logic clr = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    async_proc_paulschulz_if bus ();

    assign bus.uio_in = {5'b00000, clr, run, wr};

    async_proc_paulschulz dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        run = 1'b0;
        wr  = 1'b0;
        clr = 1'b0;
        rst = 1'b1;
        ticks(1);
        rst = 1'b0;
    endtask

    task automatic wr_byte(input logic [7:0] b);
        bus.ui_in = b;
        wr        = 1'b1;
        ticks(1);
        wr        = 1'b0;
    endtask

    initial begin
        bus.ena   = 1'b1;
        bus.ui_in = 8'h00;
        do_reset();
        check_eq("rst_uo_out", bus.uo_out, 8'h00);
        check_eq("rst_uio_out", bus.uio_out, 8'h00);
        check_eq("uio_oe", bus.uio_oe, 8'hF0);

        // LDI 5, ADDI 3, OUT, HALT
        wr_byte(8'h15); wr_byte(8'h23); wr_byte(8'h70); wr_byte(8'hF0);
        run = 1'b1;
        ticks(3);
        check_eq("t1_out", bus.uo_out, 8'h08);
        check_eq("t1_running", bus.uio_out, 8'h40);
        ticks(1);
        check_eq("t1_halted", bus.uio_out, 8'h80);
        ticks(3);
        check_eq("t1_hold", bus.uo_out, 8'h08);

        // IN, ADDI 15, OUT, HALT with ui_in=F5 -> carry out
        do_reset();
        wr_byte(8'h80); wr_byte(8'h2F); wr_byte(8'h70); wr_byte(8'hF0);
        bus.ui_in = 8'hF5;
        run = 1'b1;
        ticks(4);
        check_eq("t2_out", bus.uo_out, 8'h04);
        check_eq("t2_status", bus.uio_out, 8'hA0);

        // LDI1, SUBI1, JZ4, JMP0, OUT, HALT
        do_reset();
        wr_byte(8'h11); wr_byte(8'h31); wr_byte(8'hA4);
        wr_byte(8'h90); wr_byte(8'h70); wr_byte(8'hF0);
        run = 1'b1;
        ticks(4);
        check_eq("t3_pre_halt", bus.uio_out, 8'h50);
        ticks(1);
        check_eq("t3_out", bus.uo_out, 8'h00);
        check_eq("t3_status", bus.uio_out, 8'h90);

        // 17 writes wrap the load pointer: mem[0]=0x11 (LDI 1), LP=1
        do_reset();
        for (int i = 1; i <= 17; i++) begin
            bus.ui_in = 8'(i);
            wr        = 1'b1;
            ticks(1);
        end
        wr = 1'b0;
        wr_byte(8'h70); wr_byte(8'hF0);
        run = 1'b1;
        ticks(3);
        check_eq("t4_wrap_out", bus.uo_out, 8'h01);
        check_eq("t4_wrap_status", bus.uio_out, 8'h80);
        run = 1'b0;
        clr = 1'b1;
        wr  = 1'b1;
        ticks(1);
        clr = 1'b0;
        wr  = 1'b0;
        wr_byte(8'h1C); wr_byte(8'h70); wr_byte(8'hF0);
        run = 1'b1;
        ticks(3);
        check_eq("t4_clr_out", bus.uo_out, 8'h0C);

        // ena=0 freezes mid-run
        do_reset();
        wr_byte(8'h11); wr_byte(8'h70); wr_byte(8'h21); wr_byte(8'h70);
        wr_byte(8'h21); wr_byte(8'h70); wr_byte(8'hF0);
        run = 1'b1;
        ticks(2);
        check_eq("t5_pre", bus.uo_out, 8'h01);
        bus.ena   = 1'b0;
        bus.ui_in = 8'hAA;
        ticks(5);
        check_eq("t5_frozen_out", bus.uo_out, 8'h01);
        check_eq("t5_frozen_status", bus.uio_out, 8'h40);
        bus.ena = 1'b1;
        ticks(2);
        check_eq("t5_resume1", bus.uo_out, 8'h02);
        ticks(2);
        check_eq("t5_resume2", bus.uo_out, 8'h03);
        ticks(1);
        check_eq("t5_halted", bus.uio_out, 8'h80);

        // SHL, STM, XORM, SHR, JC, LDM, ADDM
        do_reset();
        wr_byte(8'h1C); wr_byte(8'hC0); wr_byte(8'h6F); wr_byte(8'h13);
        wr_byte(8'hEF); wr_byte(8'h70); wr_byte(8'hD0); wr_byte(8'hB9);
        wr_byte(8'hF0); wr_byte(8'h70); wr_byte(8'h5F); wr_byte(8'h4F);
        wr_byte(8'h70); wr_byte(8'hF0);
        run = 1'b1;
        ticks(6);
        check_eq("t6_xorm", bus.uo_out, 8'h1B);
        ticks(3);
        check_eq("t6_shr_jc", bus.uo_out, 8'h0D);
        check_eq("t6_carry", bus.uio_out, 8'h60);
        ticks(3);
        check_eq("t6_addm", bus.uo_out, 8'h30);
        ticks(1);
        check_eq("t6_halted", bus.uio_out, 8'h80);

        // Asynchronous reset mid-run
        do_reset();
        wr_byte(8'h19); wr_byte(8'h70); wr_byte(8'hF0);
        run = 1'b1;
        ticks(2);
        check_eq("t7_pre", bus.uo_out, 8'h09);
        #2;
        rst = 1'b1;
        #1;
        check_eq("t7_rst_uo", bus.uo_out, 8'h00);
        check_eq("t7_rst_uio", bus.uio_out, 8'h00);
        #1;
        rst = 1'b0;
        ticks(5);
        check_eq("t7_nop_out", bus.uo_out, 8'h00);
        check_eq("t7_nop_status", bus.uio_out, 8'h40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
